// File: rtl/counter_pkg.sv
// Shared definitions for the multi-channel counter bank: action codes,
// mode values and the counter maximum helper.
package counter_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,
        ACT_CLEAR = 3'd1,
        ACT_UP    = 3'd2,
        ACT_DOWN  = 3'd3,
        ACT_AUTO  = 3'd4
    } action_e;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // All-ones value of a counter of the given width; computed in 33 bits so
    // that width 32 does not overflow.
    function automatic logic [31:0] cnt_max(input int unsigned width);
        logic [32:0] m;
        m = (33'd1 << width) - 33'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel: priority decode, carry/borrow-aware next count
// and registered event triggers that line up with the registered count.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic             up,
    input  logic             down,
    input  logic             auto_en,
    input  logic             sat,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] count,
    output logic             trig_zero,
    output logic             trig_cmp,
    output logic             trig_lim
);

    localparam logic [31:0]      CNT_MAX_FULL = cnt_max(WIDTH);
    localparam logic [WIDTH-1:0] CNT_MAX      = CNT_MAX_FULL[WIDTH-1:0];

    action_e          action;
    logic [WIDTH:0]   inc_full;
    logic [WIDTH:0]   dec_full;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             trig_zero_reg, trig_zero_next;
    logic             trig_cmp_reg, trig_cmp_next;
    logic             trig_lim_reg, trig_lim_next;

    always_comb begin
        action = ACT_HOLD;
        if (clear)
            action = ACT_CLEAR;
        else if (up)
            action = ACT_UP;
        else if (down)
            action = ACT_DOWN;
        else if (auto_en && tick)
            action = ACT_AUTO;
    end

    // The extra top bit of each result flags carry out of max / borrow below 0.
    always_comb begin
        inc_full      = {1'b0, count_reg} + (WIDTH+1)'(1);
        dec_full      = {1'b0, count_reg} - (WIDTH+1)'(1);
        count_next    = count_reg;
        trig_lim_next = 1'b0;
        case (action)
            ACT_CLEAR: count_next = '0;
            ACT_UP, ACT_AUTO: begin
                if (inc_full[WIDTH]) begin
                    trig_lim_next = 1'b1;
                    if (sat == MODE_WRAP)
                        count_next = inc_full[WIDTH-1:0];
                end else begin
                    count_next = inc_full[WIDTH-1:0];
                end
            end
            ACT_DOWN: begin
                if (dec_full[WIDTH]) begin
                    trig_lim_next = 1'b1;
                    if (sat == MODE_WRAP)
                        count_next = CNT_MAX;
                end else begin
                    count_next = dec_full[WIDTH-1:0];
                end
            end
            default: count_next = count_reg;
        endcase
        // Edge-style events: only a real change of value can fire them.
        trig_zero_next = (count_next == '0) && (count_reg != '0);
        trig_cmp_next  = (count_next == cmp) && (count_next != count_reg);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            count_reg     <= '0;
            trig_zero_reg <= 1'b0;
            trig_cmp_reg  <= 1'b0;
            trig_lim_reg  <= 1'b0;
        end else begin
            count_reg     <= count_next;
            trig_zero_reg <= trig_zero_next;
            trig_cmp_reg  <= trig_cmp_next;
            trig_lim_reg  <= trig_lim_next;
        end
    end

    assign count     = count_reg;
    assign trig_zero = trig_zero_reg;
    assign trig_cmp  = trig_cmp_reg;
    assign trig_lim  = trig_lim_reg;

endmodule

// File: rtl/multi_counter_bank.sv
// Bank of independent up/down counters sharing one programmable prescaler tick.
// Controls arrive as levels; counts and event pulses are all registered.
module multi_counter_bank
    import counter_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 24
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  div_reload,
    input  logic [N_CH-1:0]       ch_clear,
    input  logic [N_CH-1:0]       ch_up,
    input  logic [N_CH-1:0]       ch_down,
    input  logic [N_CH-1:0]       ch_auto,
    input  logic [N_CH-1:0]       ch_sat,
    input  logic [N_CH*WIDTH-1:0] ch_cmp,
    output logic [N_CH*WIDTH-1:0] count,
    output logic                  tick,
    output logic [N_CH-1:0]       trig_zero,
    output logic [N_CH-1:0]       trig_cmp,
    output logic [N_CH-1:0]       trig_lim
);

    logic [DIV_WIDTH-1:0] div_cnt_reg;
    logic                 tick_reg;

    // div_reload is only sampled on reload, so a new value never cuts short
    // the period already in progress.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            div_cnt_reg <= div_reload;
            tick_reg    <= 1'b0;
        end else if (div_cnt_reg == '0) begin
            div_cnt_reg <= div_reload;
            tick_reg    <= 1'b1;
        end else begin
            div_cnt_reg <= div_cnt_reg - DIV_WIDTH'(1);
            tick_reg    <= 1'b0;
        end
    end

    assign tick = tick_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            counter_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .sys_clk   (sys_clk),
                .reset     (reset),
                .tick      (tick_reg),
                .clear     (ch_clear[gi]),
                .up        (ch_up[gi]),
                .down      (ch_down[gi]),
                .auto_en   (ch_auto[gi]),
                .sat       (ch_sat[gi]),
                .cmp       (ch_cmp[gi*WIDTH +: WIDTH]),
                .count     (count[gi*WIDTH +: WIDTH]),
                .trig_zero (trig_zero[gi]),
                .trig_cmp  (trig_cmp[gi]),
                .trig_lim  (trig_lim[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_counter_bank.sv
// Directed self-checking bench for multi_counter_bank (4 channels, 8 bits).
module tb_multi_counter_bank;

    localparam int N_CH      = 4;
    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 24;

    logic                  sys_clk;
    logic                  reset;
    logic [DIV_WIDTH-1:0]  div_reload;
    logic [N_CH-1:0]       ch_clear;
    logic [N_CH-1:0]       ch_up;
    logic [N_CH-1:0]       ch_down;
    logic [N_CH-1:0]       ch_auto;
    logic [N_CH-1:0]       ch_sat;
    logic [N_CH*WIDTH-1:0] ch_cmp;
    logic [N_CH*WIDTH-1:0] count;
    logic                  tick;
    logic [N_CH-1:0]       trig_zero;
    logic [N_CH-1:0]       trig_cmp;
    logic [N_CH-1:0]       trig_lim;

    int errors = 0;
    int checks = 0;

    multi_counter_bank #(
        .N_CH      (N_CH),
        .WIDTH     (WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .div_reload (div_reload),
        .ch_clear   (ch_clear),
        .ch_up      (ch_up),
        .ch_down    (ch_down),
        .ch_auto    (ch_auto),
        .ch_sat     (ch_sat),
        .ch_cmp     (ch_cmp),
        .count      (count),
        .tick       (tick),
        .trig_zero  (trig_zero),
        .trig_cmp   (trig_cmp),
        .trig_lim   (trig_lim)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int i);
        return count[i*WIDTH +: WIDTH];
    endfunction

    task automatic test_reset();
        reset = 1'b1; div_reload = 24'd3;
        ch_clear = '0; ch_up = '0; ch_down = '0; ch_auto = '0; ch_sat = '0; ch_cmp = '0;
        step(); step();
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %h expected 0", count); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        checks++; if (trig_zero !== '0) begin errors++; $display("FAIL reset_trig_zero: got %b expected 0", trig_zero); end
        checks++; if (trig_cmp !== '0) begin errors++; $display("FAIL reset_trig_cmp: got %b expected 0", trig_cmp); end
        checks++; if (trig_lim !== '0) begin errors++; $display("FAIL reset_trig_lim: got %b expected 0", trig_lim); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_prescaler();
        logic       exp_tick;
        logic [7:0] exp_cnt;
        ch_auto[0] = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            step();
            exp_tick = (s % 4 == 0);
            exp_cnt  = 8'((s - 1) / 4);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL presc_tick[%0d]: got %b expected %b", s, tick, exp_tick); end
            checks++; if (cnt(0) !== exp_cnt) begin errors++; $display("FAIL presc_count0[%0d]: got %h expected %h", s, cnt(0), exp_cnt); end
        end
        ch_auto[0] = 1'b0;
        checks++; if (count[N_CH*WIDTH-1:WIDTH] !== '0) begin errors++; $display("FAIL presc_others: got %h expected 0", count[N_CH*WIDTH-1:WIDTH]); end
        $display("test_prescaler done: count0=%h", cnt(0));
    endtask

    task automatic test_wrap();
        int lim_pulses  = 0;
        int zero_pulses = 0;
        ch_sat[1] = 1'b0;
        ch_up[1]  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            if (trig_lim[1] === 1'b1) lim_pulses++;
            if (trig_zero[1] === 1'b1) zero_pulses++;
            if (i == 255) begin
                checks++; if (trig_lim[1] !== 1'b1) begin errors++; $display("FAIL wrap_lim_last: got %b expected 1", trig_lim[1]); end
                checks++; if (trig_zero[1] !== 1'b1) begin errors++; $display("FAIL wrap_zero_last: got %b expected 1", trig_zero[1]); end
            end
        end
        ch_up[1] = 1'b0;
        checks++; if (cnt(1) !== 8'h00) begin errors++; $display("FAIL wrap_count1: got %h expected 00", cnt(1)); end
        checks++; if (lim_pulses !== 1) begin errors++; $display("FAIL wrap_lim_pulses: got %0d expected 1", lim_pulses); end
        checks++; if (zero_pulses !== 1) begin errors++; $display("FAIL wrap_zero_pulses: got %0d expected 1", zero_pulses); end
        checks++; if (cnt(0) !== 8'h03) begin errors++; $display("FAIL wrap_count0_indep: got %h expected 03", cnt(0)); end
        ch_down[1] = 1'b1;
        step();
        ch_down[1] = 1'b0;
        checks++; if (cnt(1) !== 8'hFF) begin errors++; $display("FAIL wrap_down_count: got %h expected ff", cnt(1)); end
        checks++; if (trig_lim[1] !== 1'b1) begin errors++; $display("FAIL wrap_down_lim: got %b expected 1", trig_lim[1]); end
        checks++; if (trig_zero[1] !== 1'b0) begin errors++; $display("FAIL wrap_down_zero: got %b expected 0", trig_zero[1]); end
        $display("test_wrap done: count1=%h", cnt(1));
    endtask

    task automatic test_saturate();
        logic exp_lim;
        ch_sat[2] = 1'b0;
        ch_down[2] = 1'b1;
        step(); step();
        ch_down[2] = 1'b0;
        checks++; if (cnt(2) !== 8'hFE) begin errors++; $display("FAIL sat_setup: got %h expected fe", cnt(2)); end
        ch_sat[2] = 1'b1;
        ch_up[2]  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            exp_lim = (c >= 2);
            checks++; if (cnt(2) !== 8'hFF) begin errors++; $display("FAIL sat_up_count[%0d]: got %h expected ff", c, cnt(2)); end
            checks++; if (trig_lim[2] !== exp_lim) begin errors++; $display("FAIL sat_up_lim[%0d]: got %b expected %b", c, trig_lim[2], exp_lim); end
            checks++; if (trig_zero[2] !== 1'b0) begin errors++; $display("FAIL sat_up_zero[%0d]: got %b expected 0", c, trig_zero[2]); end
        end
        ch_up[2] = 1'b0;
        ch_clear[2] = 1'b1;
        step();
        ch_clear[2] = 1'b0;
        ch_down[2] = 1'b1;
        step();
        ch_down[2] = 1'b0;
        checks++; if (cnt(2) !== 8'h00) begin errors++; $display("FAIL sat_down_count: got %h expected 00", cnt(2)); end
        checks++; if (trig_lim[2] !== 1'b1) begin errors++; $display("FAIL sat_down_lim: got %b expected 1", trig_lim[2]); end
        checks++; if (trig_zero[2] !== 1'b0) begin errors++; $display("FAIL sat_down_zero: got %b expected 0", trig_zero[2]); end
        $display("test_saturate done: count2=%h", cnt(2));
    endtask

    task automatic test_priority();
        ch_up[3] = 1'b1;
        repeat (5) step();
        ch_up[3] = 1'b0;
        checks++; if (cnt(3) !== 8'h05) begin errors++; $display("FAIL prio_setup: got %h expected 05", cnt(3)); end
        ch_clear[3] = 1'b1; ch_up[3] = 1'b1; ch_down[3] = 1'b1;
        step();
        checks++; if (cnt(3) !== 8'h00) begin errors++; $display("FAIL prio_clear_count: got %h expected 00", cnt(3)); end
        checks++; if (trig_zero[3] !== 1'b1) begin errors++; $display("FAIL prio_clear_zero: got %b expected 1", trig_zero[3]); end
        ch_clear[3] = 1'b0;
        step();
        ch_up[3] = 1'b0; ch_down[3] = 1'b0;
        checks++; if (cnt(3) !== 8'h01) begin errors++; $display("FAIL prio_updown_count: got %h expected 01", cnt(3)); end
        checks++; if (trig_zero[3] !== 1'b0) begin errors++; $display("FAIL prio_updown_zero: got %b expected 0", trig_zero[3]); end
        ch_clear[3] = 1'b1;
        step();
        checks++; if (trig_zero[3] !== 1'b1) begin errors++; $display("FAIL prio_clear1_zero: got %b expected 1", trig_zero[3]); end
        step();
        ch_clear[3] = 1'b0;
        checks++; if (trig_zero[3] !== 1'b0) begin errors++; $display("FAIL prio_clear0_zero: got %b expected 0", trig_zero[3]); end
        $display("test_priority done: count3=%h", cnt(3));
    endtask

    task automatic test_compare();
        int cmp_pulses = 0;
        ch_cmp[0 +: WIDTH] = 8'h10;
        ch_clear[0] = 1'b1;
        step();
        ch_clear[0] = 1'b0;
        checks++; if (cnt(0) !== 8'h00) begin errors++; $display("FAIL cmp_setup: got %h expected 00", cnt(0)); end
        ch_up[0] = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (trig_cmp[0] === 1'b1) cmp_pulses++;
            if (i == 16) begin
                checks++; if (trig_cmp[0] !== 1'b1) begin errors++; $display("FAIL cmp_hit: got %b expected 1 (count %h)", trig_cmp[0], cnt(0)); end
            end
        end
        ch_up[0] = 1'b0;
        checks++; if (cmp_pulses !== 1) begin errors++; $display("FAIL cmp_pulses: got %0d expected 1", cmp_pulses); end
        checks++; if (cnt(0) !== 8'h12) begin errors++; $display("FAIL cmp_count: got %h expected 12", cnt(0)); end
        ch_cmp[0 +: WIDTH] = 8'h20;
        ch_down[0] = 1'b1;
        step(); step();
        ch_down[0] = 1'b0;
        checks++; if (cnt(0) !== 8'h10) begin errors++; $display("FAIL cmp_down_count: got %h expected 10", cnt(0)); end
        ch_cmp[0 +: WIDTH] = 8'h10;
        step();
        checks++; if (trig_cmp[0] !== 1'b0) begin errors++; $display("FAIL cmp_static1: got %b expected 0", trig_cmp[0]); end
        step();
        checks++; if (trig_cmp[0] !== 1'b0) begin errors++; $display("FAIL cmp_static2: got %b expected 0", trig_cmp[0]); end
        $display("test_compare done: count0=%h", cnt(0));
    endtask

    task automatic test_reset_mid();
        int   waited = 0;
        logic exp_tick;
        ch_up[0] = 1'b1;
        repeat (50) step();
        ch_up[0] = 1'b0;
        checks++; if (cnt(0) !== 8'h42) begin errors++; $display("FAIL rstmid_setup: got %h expected 42", cnt(0)); end
        while (tick !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL rstmid_tick_wait: got %b expected 1 within 8 cycles", tick); end
        repeat (3) step();
        reset = 1'b1; ch_up[0] = 1'b1; ch_down[1] = 1'b1; ch_clear[2] = 1'b1;
        step();
        reset = 1'b0; ch_up[0] = 1'b0; ch_down[1] = 1'b0; ch_clear[2] = 1'b0;
        checks++; if (count !== '0) begin errors++; $display("FAIL rstmid_count: got %h expected 0", count); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick: got %b expected 0", tick); end
        checks++; if ((trig_zero | trig_cmp | trig_lim) !== '0) begin errors++; $display("FAIL rstmid_trigs: got z=%b c=%b l=%b expected 0", trig_zero, trig_cmp, trig_lim); end
        for (int s = 1; s <= 4; s++) begin
            step();
            exp_tick = (s == 4);
            checks++; if (tick !== exp_tick) begin errors++; $display("FAIL rstmid_period[%0d]: got %b expected %b", s, tick, exp_tick); end
        end
        checks++; if (cnt(0) !== 8'h00) begin errors++; $display("FAIL rstmid_count0_after: got %h expected 00", cnt(0)); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_wrap();
        test_saturate();
        test_priority();
        test_compare();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
